mv_serial_sched: RTL and testbench

- Result scheduler in front of the 20-bit serial output register of the full-search block-matching engine.
- Arbitrates round-robin among NREQ processing-element columns, each offering one {coordinate, MAD} result.
- Formats the granted result into a 20-bit frame and pulses the register's load enable.
- Holds off further loads until all 20 bits have left the serial port, and emits frame and macroblock markers for the downstream receiver.

---
 rtl/mv_serial_sched_pkg.sv | 20 ++
 rtl/mv_serial_sched_if.sv | 28 ++
 rtl/mv_serial_sched_rr_arbiter.sv | 37 +++
 rtl/mv_serial_sched.sv | 127 ++++++++++++
 tb/tb_mv_serial_sched.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mv_serial_sched_pkg.sv
// Shared widths, timing constants and state encoding for the result scheduler
// that feeds the 20-bit serial output register of the block-matching engine.
package mv_sched_pkg;

  localparam int COORD_W   = 8;
  localparam int MAD_W     = 12;
  localparam int FRAME_W   = COORD_W + MAD_W;
  localparam int SHIFT_CYC = 19;
  // ld_en to bit 19 on the port, and ld_en to bit 0 on the port
  localparam int FS_DLY    = 2;
  localparam int MB_DLY    = FS_DLY + FRAME_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} sched_state_e;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic [COORD_W-1:0] coord,
                                                    input logic [MAD_W-1:0]   mad);
    return {coord, mad};
  endfunction

endpackage

// File: rtl/mv_serial_sched_if.sv
// Requester handshake plus serial-register load/marker signals of the scheduler.
interface mv_serial_sched_if #(parameter int NREQ = 4);
  import mv_sched_pkg::*;

  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*COORD_W-1:0] req_coord;
  logic [NREQ*MAD_W-1:0]   req_mad;
  logic [NREQ-1:0]         req_ready;
  logic                    ld_en;
  logic [FRAME_W-1:0]      ld_data;
  logic [IDX_W-1:0]        src_id;
  logic                    frame_start;
  logic                    busy;
  logic                    mb_done;

  modport master (
    output req_valid, req_coord, req_mad,
    input  req_ready, ld_en, ld_data, src_id, frame_start, busy, mb_done
  );

  modport slave (
    input  req_valid, req_coord, req_mad,
    output req_ready, ld_en, ld_data, src_id, frame_start, busy, mb_done
  );

endinterface

// File: rtl/mv_serial_sched_rr_arbiter.sv
// Combinational round-robin pick: lowest valid index at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  int               sel_i;
  logic [IDX_W-1:0] sel;

  // NOTE: every variable gets a default before any conditional write so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sel_i = 0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sel_i = int'(ptr) + k;
      if (sel_i >= NREQ) sel_i = sel_i - NREQ;
      sel = IDX_W'(sel_i);
      if (en && !found && req[sel]) begin
        grant[sel] = 1'b1;
        idx        = sel;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mv_serial_sched.sv
// Round-robin result scheduler: grants one PE column, loads its {coord, MAD}
// frame into the serial register, and paces loads to the 20-bit shift time.
module mv_serial_sched
  import mv_sched_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int GAP            = 0,
  parameter int RESULTS_PER_MB = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mv_serial_sched_if.slave   bus
);

  localparam int IDX_W   = $clog2(NREQ);
  localparam int CNT_MAX = (GAP > SHIFT_CYC) ? GAP : SHIFT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FC_W    = (RESULTS_PER_MB > 1) ? $clog2(RESULTS_PER_MB) : 1;

  sched_state_e      state;
  logic [IDX_W-1:0]  ptr;
  logic [CNT_W-1:0]  cnt;
  logic [FC_W-1:0]   frame_cnt;
  logic [FS_DLY-1:0] fs_pipe;
  logic [MB_DLY-1:0] mb_pipe;

  logic [NREQ-1:0]    grant;
  logic [IDX_W-1:0]   g_idx;
  logic [COORD_W-1:0] g_coord;
  logic [MAD_W-1:0]   g_mad;
  logic               mb_wrap;

  // Grants are suppressed during reset so every output reads zero then.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .en    ((state == S_IDLE) && rst_n),
    .grant (grant),
    .idx   (g_idx)
  );

  assign bus.req_ready = grant;

  always_comb begin
    g_coord = '0;
    g_mad   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g_idx == IDX_W'(i)) begin
        g_coord = bus.req_coord[i*COORD_W +: COORD_W];
        g_mad   = bus.req_mad[i*MAD_W +: MAD_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      bus.ld_en   <= 1'b0;
      bus.ld_data <= '0;
      bus.src_id  <= '0;
      bus.busy    <= 1'b0;
    end else begin
      bus.ld_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|grant) begin
            bus.ld_data <= pack_frame(g_coord, g_mad);
            bus.src_id  <= g_idx;
            ptr         <= (g_idx == IDX_W'(NREQ - 1)) ? '0 : g_idx + 1'b1;
            bus.ld_en   <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(SHIFT_CYC - 1)) begin
            cnt <= '0;
            if (GAP > 0) begin
              state <= S_GAP;
            end else begin
              state    <= S_IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == CNT_W'(GAP - 1)) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Marker pipes run free of the FSM so overlapping frames still line up.
  assign mb_wrap = bus.ld_en && (frame_cnt == FC_W'(RESULTS_PER_MB - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      fs_pipe   <= '0;
      mb_pipe   <= '0;
    end else begin
      fs_pipe <= {fs_pipe[FS_DLY-2:0], bus.ld_en};
      mb_pipe <= {mb_pipe[MB_DLY-2:0], mb_wrap};
      if (bus.ld_en) frame_cnt <= mb_wrap ? '0 : frame_cnt + 1'b1;
    end
  end

  assign bus.frame_start = fs_pipe[FS_DLY-1];
  assign bus.mb_done     = mb_pipe[MB_DLY-1];

endmodule

// File: tb/tb_mv_serial_sched.sv
// Directed bench for mv_serial_sched: GAP=0 instance for grant order, timing,
// markers and mid-frame reset; GAP=3 instance for frame spacing.
module tb_mv_serial_sched;
  import mv_sched_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mv_serial_sched_if #(.NREQ(4)) bus0 ();
  mv_serial_sched_if #(.NREQ(4)) bus1 ();

  mv_serial_sched #(.NREQ(4), .GAP(0), .RESULTS_PER_MB(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  mv_serial_sched #(.NREQ(4), .GAP(3), .RESULTS_PER_MB(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          ld0_cyc[$];
  int          ld0_src[$];
  logic [19:0] ld0_data[$];
  int          fs0_cyc[$];
  int          mb0_cyc[$];
  int          busy0_cnt;
  int          ld1_cyc[$];
  int          ld1_src[$];
  int          rdy1_cnt;

  int          exp0_c[5] = '{1, 22, 43, 64, 85};
  int          exp0_s[5] = '{0, 1, 2, 3, 0};
  logic [19:0] exp0_d[5] = '{20'hA00F0, 20'hA10F1, 20'hA20F2, 20'hA30F3, 20'hA00F0};
  int          exp1_c[4] = '{1, 25, 49, 73};
  int          exp1_s[4] = '{0, 2, 0, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    if (bus0.ld_en === 1'b1) begin
      ld0_cyc.push_back(cyc);
      ld0_src.push_back(int'(bus0.src_id));
      ld0_data.push_back(bus0.ld_data);
    end
    if (bus0.frame_start === 1'b1) fs0_cyc.push_back(cyc);
    if (bus0.mb_done === 1'b1)     mb0_cyc.push_back(cyc);
    if (bus0.busy === 1'b1)        busy0_cnt++;
    if (bus1.ld_en === 1'b1) begin
      ld1_cyc.push_back(cyc);
      ld1_src.push_back(int'(bus1.src_id));
    end
    if (bus1.req_ready !== 4'b0000) rdy1_cnt++;
  endtask

  task automatic clear_logs();
    ld0_cyc.delete(); ld0_src.delete(); ld0_data.delete();
    fs0_cyc.delete(); mb0_cyc.delete();
    ld1_cyc.delete(); ld1_src.delete();
    busy0_cnt = 0;
    rdy1_cnt  = 0;
    cyc       = 0;
  endtask

  task automatic check_zero(input string p);
    check({p, "_ld_en"},       bus0.ld_en,       32'h0);
    check({p, "_ld_data"},     bus0.ld_data,     32'h0);
    check({p, "_src_id"},      bus0.src_id,      32'h0);
    check({p, "_frame_start"}, bus0.frame_start, 32'h0);
    check({p, "_busy"},        bus0.busy,        32'h0);
    check({p, "_mb_done"},     bus0.mb_done,     32'h0);
    check({p, "_req_ready"},   bus0.req_ready,   32'h0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus0.req_valid = 4'b0000;
    bus1.req_valid = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus0.req_valid = 4'b1111;
    bus0.req_coord = '0;
    bus0.req_mad   = '0;
    bus1.req_valid = 4'b0000;
    bus1.req_coord = '0;
    bus1.req_mad   = '0;

    // Reset state, with requests pending to show grants are held off
    tick();
    tick();
    check_zero("rst");
    bus0.req_valid = 4'b0000;
    rst_n = 1'b1;

    // Single request from column 2
    clear_logs();
    bus0.req_coord = 32'h005A0000;
    bus0.req_mad   = 48'h0003C7000000;
    bus0.req_valid = 4'b0100;
    #1;
    check("single_ready", bus0.req_ready, 32'h4);
    check("single_busy_t", bus0.busy, 32'h0);
    tick();
    check("single_ld_en", bus0.ld_en, 32'h1);
    check("single_ld_data", bus0.ld_data, 32'h5A3C7);
    check("single_src_id", bus0.src_id, 32'h2);
    check("single_ready_busy", bus0.req_ready, 32'h0);
    bus0.req_valid = 4'b0000;
    repeat (20) tick();
    check("single_busy_cycles", busy0_cnt, 32'd20);
    check("single_busy_end", bus0.busy, 32'h0);
    check("single_fs_count", fs0_cyc.size(), 32'd1);
    check("single_fs_cycle", fs0_cyc[0], 32'd3);
    check("single_ld_count", ld0_cyc.size(), 32'd1);
    tick();
    check("single_no_mb", mb0_cyc.size(), 32'd0);

    // Wrap: pointer sits at 3 after the column-2 grant
    bus0.req_coord = 32'h33000011;
    bus0.req_mad   = 48'h444000000222;
    bus0.req_valid = 4'b1001;
    #1;
    check("wrap_ready3", bus0.req_ready, 32'h8);
    tick();
    check("wrap_src3", bus0.src_id, 32'h3);
    check("wrap_data3", bus0.ld_data, 32'h33444);
    bus0.req_valid = 4'b0001;
    repeat (20) tick();
    check("wrap_ready0", bus0.req_ready, 32'h1);
    tick();
    check("wrap_src0", bus0.src_id, 32'h0);
    check("wrap_data0", bus0.ld_data, 32'h11222);
    bus0.req_coord = 32'h00007700;
    bus0.req_mad   = 48'h000000888000;
    bus0.req_valid = 4'b0010;
    repeat (20) tick();
    check("wrap_ready1", bus0.req_ready, 32'h2);
    tick();
    check("wrap_src1", bus0.src_id, 32'h1);
    check("wrap_data1", bus0.ld_data, 32'h77888);
    bus0.req_valid = 4'b0000;

    // Round-robin with all columns valid (GAP=0) and GAP=3 spacing in parallel
    do_reset();
    clear_logs();
    bus0.req_coord = 32'hA3A2A1A0;
    bus0.req_mad   = 48'h0F30F20F10F0;
    bus0.req_valid = 4'b1111;
    bus1.req_coord = 32'h00C000B0;
    bus1.req_mad   = 48'h0005C50005B5;
    bus1.req_valid = 4'b0101;
    #1;
    check("rr_ready_first", bus0.req_ready, 32'h1);
    check("gap_ready_first", bus1.req_ready, 32'h1);
    repeat (90) tick();
    check("rr_ld_count", ld0_cyc.size(), 32'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr_ld_cyc%0d", k), ld0_cyc[k], exp0_c[k]);
      check($sformatf("rr_src%0d", k), ld0_src[k], exp0_s[k]);
      check($sformatf("rr_data%0d", k), ld0_data[k], exp0_d[k]);
    end
    check("rr_fs_first", fs0_cyc[0], 32'd3);
    check("rr_fs_last", fs0_cyc[fs0_cyc.size()-1], 32'd87);
    check("mb_count", mb0_cyc.size(), 32'd1);
    check("mb_cycle", mb0_cyc[0], 32'd85);
    check("gap_ld_count", ld1_cyc.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("gap_ld_cyc%0d", k), ld1_cyc[k], exp1_c[k]);
      check($sformatf("gap_src%0d", k), ld1_src[k], exp1_s[k]);
    end
    check("gap_ready_cycles", rdy1_cnt, 32'd3);
    bus0.req_valid = 4'b0000;
    bus1.req_valid = 4'b0000;

    // Reset in SHIFT at count 10 of what would be the fourth frame
    do_reset();
    clear_logs();
    bus0.req_coord = 32'h005A00E0;
    bus0.req_mad   = 48'h0003C7000E0E;
    bus0.req_valid = 4'b0001;
    repeat (43) tick();
    bus0.req_valid = 4'b0100;
    repeat (20) tick();
    #1;
    check("mid_ready2", bus0.req_ready, 32'h4);
    tick();
    check("mid_ld_en", bus0.ld_en, 32'h1);
    check("mid_src2", bus0.src_id, 32'h2);
    bus0.req_valid = 4'b0000;
    repeat (11) tick();
    check("mid_busy_pre", bus0.busy, 32'h1);
    rst_n = 1'b0;
    tick();
    check_zero("mid");
    rst_n = 1'b1;
    mb0_cyc.delete();
    bus0.req_coord = 32'h73007100;
    bus0.req_mad   = 48'h373000171000;
    bus0.req_valid = 4'b1010;
    #1;
    check("mid_ready_ptr0", bus0.req_ready, 32'h2);
    tick();
    check("mid_fresh_ld_en", bus0.ld_en, 32'h1);
    check("mid_fresh_src", bus0.src_id, 32'h1);
    check("mid_fresh_data", bus0.ld_data, 32'h71171);
    bus0.req_valid = 4'b0000;
    repeat (30) tick();
    check("mid_no_mb", mb0_cyc.size(), 32'd0);
    check("mid_fresh_fs", fs0_cyc[fs0_cyc.size()-1], 32'd79);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
